// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl
// Sequencer for an iterative AES decryption datapath. Takes one block and
// its initial round key, applies the initial AddRoundKey and then feeds
// state and key back through an external combinational round NR times.
// The result is held until the consumer takes it.
// Optional feature macro: AES_INV_CTRL_ABORT_EN adds an `abort` input that
// drops an in-flight or finished block and clears all round state.

module aes_inv_round_ctrl #(
   parameter int NR   = 10,
   parameter int RC_W = 4,
   parameter int DW   = 128
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   data_in,
   input  logic [DW-1:0]   key_in,
   output logic [RC_W-1:0] rc_round,
   output logic            rnd_final,
   output logic [DW-1:0]   ko,
   output logic [DW-1:0]   rnd_state,
   input  logic [DW-1:0]   key_nxt,
   input  logic [DW-1:0]   rnd_nxt,
   output logic            out_valid,
   input  logic            out_ready,
`ifdef AES_INV_CTRL_ABORT_EN
   input  logic            abort,
`endif
   output logic [DW-1:0]   data_out
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } fsm_t;

   localparam logic [RC_W-1:0] CNT_ONE  = RC_W'(1);
   localparam logic [RC_W-1:0] CNT_LAST = RC_W'(NR);

   fsm_t            fsm_q, fsm_d;
   logic [RC_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]   st_q, st_d;
   logic [DW-1:0]   key_q, key_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic [RC_W-1:0] rc_round_q, rc_round_d;
   logic            rnd_final_q, rnd_final_d;
   logic [DW-1:0]   data_out_q, data_out_d;
   logic            abort_w;

`ifdef AES_INV_CTRL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Next-state logic for the sequencer plus the registered output values,
   // derived from the next state so outputs line up with the state they describe.
   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      st_d  = st_q;
      key_d = key_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               st_d  = data_in ^ key_in;
               key_d = key_in;
               cnt_d = CNT_ONE;
               fsm_d = S_ROUND;
            end
         end
         S_ROUND: begin
            if (abort_w) begin
               fsm_d = S_IDLE;
               cnt_d = '0;
               st_d  = '0;
               key_d = '0;
            end else begin
               st_d  = rnd_nxt;
               key_d = key_nxt;
               if (cnt_q == CNT_LAST) begin
                  fsm_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         S_DONE: begin
            if (abort_w) begin
               fsm_d = S_IDLE;
               cnt_d = '0;
               st_d  = '0;
               key_d = '0;
            end else if (out_ready) begin
               // State register keeps the result until the next accept.
               fsm_d = S_IDLE;
               cnt_d = '0;
            end
         end
         default: begin
            fsm_d = S_IDLE;
            cnt_d = '0;
         end
      endcase

      in_ready_d  = (fsm_d == S_IDLE);
      out_valid_d = (fsm_d == S_DONE);
      rc_round_d  = (fsm_d == S_ROUND) ? cnt_d : '0;
      rnd_final_d = (fsm_d == S_ROUND) && (cnt_d == CNT_LAST);
      data_out_d  = (fsm_d == S_DONE) ? st_d : '0;
   end

   // Single register bank for FSM, counter, round state, key and outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= S_IDLE;
         cnt_q       <= '0;
         st_q        <= '0;
         key_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         rc_round_q  <= '0;
         rnd_final_q <= 1'b0;
         data_out_q  <= '0;
      end else begin
         fsm_q       <= fsm_d;
         cnt_q       <= cnt_d;
         st_q        <= st_d;
         key_q       <= key_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         rc_round_q  <= rc_round_d;
         rnd_final_q <= rnd_final_d;
         data_out_q  <= data_out_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign rc_round  = rc_round_q;
   assign rnd_final = rnd_final_q;
   assign data_out  = data_out_q;
   assign ko        = key_q;
   assign rnd_state = st_q;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: supplies a combinational AES inverse round
// datapath, keeps a cycle-level model of the handshake/sequencing rules and
// an AES-128 reference decryption, and compares outputs every cycle.

module tb_aes_inv_round_ctrl;

   localparam int NR      = 10;
   localparam int DONE_PH = NR + 1;

   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] data_in;
   logic [127:0] key_in;
   logic [3:0]   rc_round;
   logic         rnd_final;
   logic [127:0] ko;
   logic [127:0] rnd_state;
   logic [127:0] key_nxt;
   logic [127:0] rnd_nxt;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] data_out;
`ifdef AES_INV_CTRL_ABORT_EN
   logic         abort;
`endif

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cyc = 0;

   // model state
   int           m_phase = 0;
   logic [127:0] m_ct = '0, m_key = '0, m_res = '0, m_hold = '0;

   always #5 clk = ~clk;

   aes_inv_round_ctrl #(.NR(NR), .RC_W(4), .DW(128)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .key_in(key_in), .rc_round(rc_round),
      .rnd_final(rnd_final), .ko(ko), .rnd_state(rnd_state),
      .key_nxt(key_nxt), .rnd_nxt(rnd_nxt), .out_valid(out_valid),
      .out_ready(out_ready),
`ifdef AES_INV_CTRL_ABORT_EN
      .abort(abort),
`endif
      .data_out(data_out)
   );

   // ---------------- AES helpers ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xt(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] sq = x;
      logic [7:0] r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = ginv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] isbox(input logic [7:0] y);
      return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
   endfunction

   function automatic logic [127:0] isr_isb(input logic [127:0] s);
      logic [127:0] o = '0;
      int src, dst;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            src = r + 4 * ((c - r + 4) % 4);
            dst = r + 4 * c;
            o[127-8*dst -: 8] = isbox(s[127-8*src -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] imc(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   function automatic logic [7:0] rcon(input int n);
      logic [7:0] r = 8'h01;
      for (int i = 1; i < n; i++) r = xt(r);
      return r;
   endfunction

   // Previous round key from the current one (inverse key expansion step).
   function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3, rw;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      rw = {p3[23:0], p3[31:24]};
      p0 = k[127:96] ^ {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])} ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
      logic [127:0] t;
      t = isr_isb(s) ^ k;
      return fin ? t : imc(t);
   endfunction

   // Whole-block reference decryption from the last round key.
   function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
      logic [127:0] s, k;
      k = key;
      s = ct ^ k;
      for (int r = 1; r <= NR; r++) begin
         k = inv_key(k, rcon(NR + 1 - r));
         s = inv_round(s, k, r == NR);
      end
      return s;
   endfunction

   // Combinational datapath driven by the controller
   always_comb begin
      logic [127:0] kn;
      kn      = inv_key(ko, rcon(NR + 1 - int'(rc_round)));
      key_nxt = kn;
      rnd_nxt = inv_round(rnd_state, kn, rnd_final);
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1..NR round index, NR+1 result held.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_phase = 0;
         m_hold  = '0;
      end else begin
`ifdef AES_INV_CTRL_ABORT_EN
         if (abort && m_phase != 0) begin
            m_phase = 0;
            m_hold  = '0;
         end else
`endif
         if (m_phase == 0) begin
            if (in_valid) begin
               m_phase = 1;
               m_ct    = data_in;
               m_key   = key_in;
               m_res   = aes_dec(data_in, key_in);
            end
         end else if (m_phase < DONE_PH) begin
            m_phase++;
            if (m_phase == DONE_PH) m_hold = m_res;
         end else if (out_ready) begin
            m_phase = 0;
         end
      end
   end

   // Per-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (rst) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_rc_round", rc_round, 0);
         chk("rst_rnd_final", rnd_final, 0);
         chk("rst_ko", ko, 0);
         chk("rst_rnd_state", rnd_state, 0);
         chk("rst_data_out", data_out, 0);
      end else begin
         chk("in_ready", in_ready, m_phase == 0);
         chk("out_valid", out_valid, m_phase == DONE_PH);
         chk("rc_round", rc_round, (m_phase >= 1 && m_phase <= NR) ? m_phase : 0);
         chk("rnd_final", rnd_final, m_phase == NR);
         chk("data_out", data_out, (m_phase == DONE_PH) ? m_res : 128'h0);
         if (m_phase == 1) begin
            chk("first_ko", ko, m_key);
            chk("first_state", rnd_state, m_ct ^ m_key);
         end
         if (m_phase == 0) chk("idle_state_hold", rnd_state, m_hold);
         if (m_phase == DONE_PH) chk("done_state", rnd_state, m_res);
      end
   end

   task automatic send(input logic [127:0] ct, input logic [127:0] key, input logic hold);
      logic acc = 1'b0;
      data_in  = ct;
      key_in   = key;
      in_valid = 1'b1;
      for (int i = 0; i < 60 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #2;
      end
      if (!acc) chk("accept_timeout", 0, 1);
      acc_cyc = cyc;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      logic seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      if (!seen) chk("valid_timeout", 0, 1);
      lat = cyc - acc_cyc;
   endtask

   task automatic wait_rc(input int v);
      logic seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (rc_round == 4'(v));
      end
      if (!seen) chk("rc_wait_timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, v1, nfin;
      logic [127:0] held;
      rst       = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      key_in    = '0;
      out_ready = 1'b1;
`ifdef AES_INV_CTRL_ABORT_EN
      abort     = 1'b0;
`endif
      // reference pinned to published vectors
      chk("ref_c1", aes_dec(CT1, K1), PT1);
      chk("ref_b", aes_dec(CT2, K2), PT2);

      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;

      // C.1 vector with sequencing
      send(CT1, K1, 1'b0);
      nfin = 0;
      for (int i = 1; i <= NR; i++) begin
         @(negedge clk);
         if (i < NR || !out_valid) begin
            chk("seq_rc", rc_round, (i <= NR - 1 || rc_round != 0) ? i : 0);
         end
         if (rnd_final) nfin++;
      end
      @(negedge clk);
      chk("c1_valid", out_valid, 1);
      chk("c1_latency", cyc - acc_cyc, NR);
      chk("c1_data", data_out, PT1);
      chk("c1_final_count", nfin, 1);
      @(posedge clk);
      #2;

      // backpressure in DONE
      out_ready = 1'b0;
      send(CT2, K2, 1'b0);
      wait_valid(lat);
      chk("bp_latency", lat, NR);
      chk("bp_data", data_out, PT2);
      held = data_out;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         in_valid = (i == 2);
         data_in  = 128'hdeadbeef;
         key_in   = 128'h12345678;
         @(negedge clk);
         chk("bp_valid_hold", out_valid, 1);
         chk("bp_data_hold", data_out, held);
         chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #2;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_ready", in_ready, 1);
      chk("bp_release_valid", out_valid, 0);
      @(posedge clk);
      #2;

      // reset in the middle of a block
      send(CT1, K1, 1'b0);
      wait_rc(4);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_rc", rc_round, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_ko", ko, 0);
      chk("mid_rst_state", rnd_state, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      send(CT2, K2, 1'b0);
      wait_valid(lat);
      chk("post_rst_latency", lat, NR);
      chk("post_rst_data", data_out, PT2);
      @(posedge clk);
      #2;

      // back-to-back with in_valid held high
      out_ready = 1'b1;
      send(CT1, K1, 1'b1);
      data_in = CT2;
      key_in  = K2;
      wait_valid(lat);
      v1 = cyc;
      chk("b2b_lat1", lat, NR);
      chk("b2b_data1", data_out, PT1);
      send(CT2, K2, 1'b0);
      chk("b2b_gap", acc_cyc - v1, 2);
      wait_valid(lat);
      chk("b2b_lat2", lat, NR);
      chk("b2b_data2", data_out, PT2);
      @(posedge clk);
      #2;

`ifdef AES_INV_CTRL_ABORT_EN
      // abort mid-block
      send(CT1, K1, 1'b0);
      wait_rc(6);
      #1 abort = 1'b1;
      @(posedge clk);
      #2 abort = 1'b0;
      @(negedge clk);
      chk("abort_ready", in_ready, 1);
      chk("abort_rc", rc_round, 0);
      chk("abort_ko", ko, 0);
      chk("abort_state", rnd_state, 0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
      end
      @(posedge clk);
      #2;
      send(CT2, K2, 1'b0);
      wait_valid(lat);
      chk("abort_next_latency", lat, NR);
      chk("abort_next_data", data_out, PT2);
      @(posedge clk);
      #2;
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
